// File: rtl/sva_result_pkg.sv
// Shared types and helpers for the SVA result collector.
//   sva_rec_t     : packed per-window summary record {stamp, n_succ, n_fail, n_lazy}
//                   at the default widths (16-bit stamp, 4-bit counters)
//   sva_verdict_t : overall run verdict encoding
//   sat_inc       : saturating increment for counters up to 32 bits wide
package sva_result_pkg;

  localparam int unsigned SVA_STAMP_W   = 16;
  localparam int unsigned SVA_WIN_CNT_W = 4;

  typedef struct packed {
    logic [SVA_STAMP_W-1:0]   stamp;
    logic [SVA_WIN_CNT_W-1:0] n_succ;
    logic [SVA_WIN_CNT_W-1:0] n_fail;
    logic [SVA_WIN_CNT_W-1:0] n_lazy;
  } sva_rec_t;

  typedef enum logic [1:0] {
    V_IDLE = 2'd0,
    V_RUN  = 2'd1,
    V_LAZY = 2'd2,
    V_FAIL = 2'd3
  } sva_verdict_t;

  // Counters are zero-extended into 32 bits by the caller and truncated back.
  function automatic logic [31:0] sat_inc(input logic [31:0] v,
                                          input logic [31:0] max_v,
                                          input logic        en);
    if (en && (v < max_v)) return v + 32'd1;
    return v;
  endfunction

endpackage

// File: rtl/sva_result_fifo.sv
// Synchronous record FIFO with valid/ready head interface.
//   sys_clk, sys_rst_n : clock, asynchronous active-low reset
//   clr                : synchronous flush (priority over push/pop)
//   push, push_data    : write request; ignored when full unless a pop frees a slot
//   pop_ready          : consumer accepts head when head_valid is high
//   head_valid         : FIFO not empty
//   head_data          : oldest record, forced to zero while empty
//   drop               : push was refused because the FIFO was full
module sva_result_fifo #(
  parameter int unsigned DW    = 28,
  parameter int unsigned DEPTH = 8
) (
  input  logic          sys_clk,
  input  logic          sys_rst_n,
  input  logic          clr,
  input  logic          push,
  input  logic [DW-1:0] push_data,
  input  logic          pop_ready,
  output logic          head_valid,
  output logic [DW-1:0] head_data,
  output logic          drop
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [DW-1:0] mem [DEPTH];
  logic [AW:0]   wr_ptr;
  logic [AW:0]   rd_ptr;
  logic          empty;
  logic          full;
  logic          pop_ok;
  logic          push_ok;

  // Extra MSB on each pointer distinguishes full from empty when the indices match.
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pop_ok  = pop_ready & ~empty;
  // A same-cycle pop frees the head slot, so a push into a full FIFO still lands.
  assign push_ok = push & (~full | pop_ok);
  assign drop    = push & full & ~pop_ok;

  assign head_valid = ~empty;
  assign head_data  = empty ? '0 : mem[rd_ptr[AW-1:0]];

  always_ff @(posedge sys_clk) begin
    if (push_ok && !clr) mem[wr_ptr[AW-1:0]] <= push_data;
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

endmodule

// File: rtl/sva_result_collector.sv
// Bins SVA checker pulses (succ/fail/lazy_succ) into gclk evaluation windows,
// queues per-window records, and keeps run-level totals and a verdict.
//   sys_clk, sys_rst_n  : system clock, asynchronous active-low reset
//   clr                 : synchronous clear of all state, overrides other inputs
//   win_tick, win_stamp : closes the open window / opens a new one stamped win_stamp
//   succ, fail, lazy_succ : one-cycle checker pulses
//   rec_valid/ready/data  : record FIFO head, rec_data = {stamp,n_succ,n_fail,n_lazy}
//   total_*             : saturating run totals, updated one cycle after the event
//   first_fail_valid/stamp : window stamp of the first fail (0 if no window open)
//   verdict             : sva_verdict_t
//   overflow            : sticky, a record was dropped on a full FIFO
//   orphan              : sticky, an event arrived with no window open
// WIN_CNT_W and CNT_W must not exceed 32.
module sva_result_collector
  import sva_result_pkg::*;
#(
  parameter int unsigned STAMP_W    = 16,
  parameter int unsigned WIN_CNT_W  = 4,
  parameter int unsigned CNT_W      = 32,
  parameter int unsigned DEPTH      = 8,
  parameter int unsigned EMIT_EMPTY = 0
) (
  input  logic                         sys_clk,
  input  logic                         sys_rst_n,
  input  logic                         clr,
  input  logic                         win_tick,
  input  logic [STAMP_W-1:0]           win_stamp,
  input  logic                         succ,
  input  logic                         fail,
  input  logic                         lazy_succ,
  output logic                         rec_valid,
  input  logic                         rec_ready,
  output logic [STAMP_W+3*WIN_CNT_W-1:0] rec_data,
  output logic [CNT_W-1:0]             total_succ,
  output logic [CNT_W-1:0]             total_fail,
  output logic [CNT_W-1:0]             total_lazy,
  output logic                         first_fail_valid,
  output logic [STAMP_W-1:0]           first_fail_stamp,
  output logic [1:0]                   verdict,
  output logic                         overflow,
  output logic                         orphan
);

  localparam int unsigned REC_W   = STAMP_W + 3*WIN_CNT_W;
  localparam logic [31:0] WIN_MAX = 32'((64'd1 << WIN_CNT_W) - 64'd1);
  localparam logic [31:0] CNT_MAX = 32'((64'd1 << CNT_W) - 64'd1);

  logic                 win_open;
  logic [STAMP_W-1:0]   cur_stamp;
  logic [WIN_CNT_W-1:0] w_succ, w_fail, w_lazy;
  logic [WIN_CNT_W-1:0] nxt_succ, nxt_fail, nxt_lazy;
  logic [CNT_W-1:0]     tot_succ_q, tot_fail_q, tot_lazy_q;
  logic                 ff_valid_q;
  logic [STAMP_W-1:0]   ff_stamp_q;
  sva_verdict_t         verdict_q;
  logic                 overflow_q;
  logic                 orphan_q;
  logic                 rec_push;
  logic [REC_W-1:0]     rec_in;
  logic                 fifo_drop;

  // Window counts including this cycle's events; a closing record uses these.
  always_comb begin
    nxt_succ = WIN_CNT_W'(sat_inc(32'(w_succ), WIN_MAX, succ      & win_open));
    nxt_fail = WIN_CNT_W'(sat_inc(32'(w_fail), WIN_MAX, fail      & win_open));
    nxt_lazy = WIN_CNT_W'(sat_inc(32'(w_lazy), WIN_MAX, lazy_succ & win_open));
    rec_in   = {cur_stamp, nxt_succ, nxt_fail, nxt_lazy};
    rec_push = win_tick & win_open &
               ((|{nxt_succ, nxt_fail, nxt_lazy}) | (EMIT_EMPTY != 0));
  end

  sva_result_fifo #(
    .DW    (REC_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .sys_clk    (sys_clk),
    .sys_rst_n  (sys_rst_n),
    .clr        (clr),
    .push       (rec_push),
    .push_data  (rec_in),
    .pop_ready  (rec_ready),
    .head_valid (rec_valid),
    .head_data  (rec_data),
    .drop       (fifo_drop)
  );

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      win_open   <= 1'b0;
      cur_stamp  <= '0;
      w_succ     <= '0;
      w_fail     <= '0;
      w_lazy     <= '0;
      tot_succ_q <= '0;
      tot_fail_q <= '0;
      tot_lazy_q <= '0;
      ff_valid_q <= 1'b0;
      ff_stamp_q <= '0;
      verdict_q  <= V_IDLE;
      overflow_q <= 1'b0;
      orphan_q   <= 1'b0;
    end else if (clr) begin
      win_open   <= 1'b0;
      cur_stamp  <= '0;
      w_succ     <= '0;
      w_fail     <= '0;
      w_lazy     <= '0;
      tot_succ_q <= '0;
      tot_fail_q <= '0;
      tot_lazy_q <= '0;
      ff_valid_q <= 1'b0;
      ff_stamp_q <= '0;
      verdict_q  <= V_IDLE;
      overflow_q <= 1'b0;
      orphan_q   <= 1'b0;
    end else begin
      tot_succ_q <= CNT_W'(sat_inc(32'(tot_succ_q), CNT_MAX, succ));
      tot_fail_q <= CNT_W'(sat_inc(32'(tot_fail_q), CNT_MAX, fail));
      tot_lazy_q <= CNT_W'(sat_inc(32'(tot_lazy_q), CNT_MAX, lazy_succ));

      if (!win_open && (succ || fail || lazy_succ)) orphan_q <= 1'b1;
      if (fifo_drop) overflow_q <= 1'b1;

      if (fail && !ff_valid_q) begin
        ff_valid_q <= 1'b1;
        ff_stamp_q <= win_open ? cur_stamp : '0;
      end

      if (win_tick) begin
        win_open  <= 1'b1;
        cur_stamp <= win_stamp;
        w_succ    <= '0;
        w_fail    <= '0;
        w_lazy    <= '0;
      end else begin
        w_succ <= nxt_succ;
        w_fail <= nxt_fail;
        w_lazy <= nxt_lazy;
      end

      if (fail) begin
        verdict_q <= V_FAIL;
      end else begin
        unique case (verdict_q)
          V_IDLE:  if (win_tick)  verdict_q <= V_RUN;
          V_RUN:   if (lazy_succ) verdict_q <= V_LAZY;
          V_LAZY:  verdict_q <= V_LAZY;
          V_FAIL:  verdict_q <= V_FAIL;
          default: verdict_q <= V_IDLE;
        endcase
      end
    end
  end

  assign total_succ       = tot_succ_q;
  assign total_fail       = tot_fail_q;
  assign total_lazy       = tot_lazy_q;
  assign first_fail_valid = ff_valid_q;
  assign first_fail_stamp = ff_stamp_q;
  assign verdict          = verdict_q;
  assign overflow         = overflow_q;
  assign orphan           = orphan_q;

endmodule
